mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Load/store stage between execute and write.
- Consumes the execute result (effective address or ALU value) plus the rs2 store data, and performs at most one data-memory transaction per instruction over a req/gnt/rvalid handshake.
- Returns the value for write-back on `rd_out` with a one-cycle `completed` pulse, matching the enabled/completed pattern of the other stages.
- Non-memory instructions pass straight through in one cycle.

Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ plus WAIT_R before the access is abandoned with `fault`.
- ADDR_MASK, 32'hFFFF_FFFF: ANDed onto `mem_addr` to fold the data space onto the physical RAM.

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous active-low reset
- enabled  input  1  start pulse; sampled only in IDLE
- is_load  input  1  instruction is a load
- is_store  input  1  instruction is a store
- funct3  input  3  access size/sign (RV32I encoding)
- addr  input  32  byte address (execute result)
- store_data  input  32  rs2 value
- rd_in  input  32  execute result; passed through for non-memory ops
- completed  output  1  one-cycle done pulse
- busy  output  1  state != IDLE
- rd_out  output  32  write-back value
- fault  output  1  misaligned, illegal or timed-out access; held until the next accepted `enabled`
- mem_req  output  1  request valid
- mem_we  output  1  1 = write
- mem_addr  output  32  word-aligned byte address
- mem_wdata  output  32  lane-aligned store data
- mem_wstrb  output  4  byte enables
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read data

Behaviour:
- Reset: asynchronous, active-low.
  - State goes to IDLE; timeout counter is cleared.
  - All outputs are 0.
  - Reset in any state aborts the operation. A late `mem_rvalid` arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT_R, DONE. All outputs are registered.
- IDLE, when `enabled`=1: latch all inputs and clear `fault`, then branch:
  - Neither load nor store: `rd_out` <= `rd_in`; go to DONE.
  - Both load and store set, or funct3 unsupported: `fault`=1, `rd_out`=0, DONE, no memory access.
    - Supported loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
    - Supported stores: 000 SB, 001 SH, 010 SW.
  - Misaligned (halfword with addr[0]=1, or word with addr[1:0]!=0): `fault`=1, `rd_out`=0, DONE, no memory access.
  - Otherwise: go to REQ, with memory outputs driven as follows.
    - `mem_addr` = {addr[31:2],2'b00} & ADDR_MASK.
    - `mem_we` = is_store.
    - SB: `mem_wstrb` = 4'b0001<<addr[1:0], `mem_wdata` = byte replicated ×4.
    - SH: `mem_wstrb` = 4'b0011<<addr[1:0], `mem_wdata` = half replicated ×2.
    - SW: `mem_wstrb` = 4'b1111.
    - Loads: `mem_wstrb` = 0.
- REQ:
  - `mem_req`=1; address, data and strobes are held stable until `mem_gnt`.
  - On `mem_gnt`: `mem_req` drops next cycle. A store goes to DONE with `rd_out`=0; a load goes to WAIT_R.
  - `mem_rvalid` seen while in REQ is ignored.
- WAIT_R, on `mem_rvalid`:
  - Select the lane by addr[1:0] (byte) or addr[1] (half).
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Write the result to `rd_out`; go to DONE.
- Timeout:
  - The counter increments each cycle in REQ or WAIT_R.
  - On reaching TIMEOUT: `fault`=1, `rd_out`=0, `mem_req`=0, go to DONE.
  - The counter clears on entering IDLE.
  - If grant/rvalid and the timeout fall in the same cycle, grant/rvalid wins.
- DONE: `completed`=1 for exactly one cycle; go to IDLE. `rd_out` holds until the next accepted `enabled`.
- `enabled` outside IDLE is ignored. Upstream must wait for `completed` before issuing the next instruction.
- Latency, counted from `enabled` in cycle 0:
  - Pass-through or fault: `completed` in cycle 1.
  - Store with immediate grant: `completed` in cycle 2.
  - Load with immediate grant and rvalid one cycle later: `completed` in cycle 3.

Test Plan:
- Pass-through: `enabled`, is_load=is_store=0, `rd_in`=32'h1234 -> cycle 1: `completed`=1, `rd_out`=32'h1234, `mem_req` never asserted.
- SB at addr=32'h103, store_data=32'hAB -> `mem_addr`=32'h100, `mem_wstrb`=4'b1000, `mem_wdata`=32'hABABABAB, `mem_we`=1. With `mem_gnt` held low 3 cycles, `mem_req` stays 1 with stable data; `completed` 1 cycle after grant.
- Load lanes with `mem_rdata`=32'h80FF7F01:
  - LB at addr 2 -> `rd_out`=32'hFFFFFFFF.
  - LBU at addr 3 -> 32'h00000080.
  - LH at addr 2 -> 32'hFFFF80FF.
  - LHU at addr 0 -> 32'h00007F01.
  - LW at addr 0 -> 32'h80FF7F01.
- Misaligned LW at addr=32'h102 -> cycle 1: `fault`=1, `completed`=1, `rd_out`=0, no `mem_req`. The next valid op clears `fault`.
- TIMEOUT=4, load granted but `mem_rvalid` never arrives -> `fault`=1, `completed` pulses. A later `mem_rvalid` pulse in IDLE leaves `rd_out`=0.
- `rstn` low in WAIT_R -> immediately `busy`=0, `mem_req`=0, `completed`=0. After release, a new `enabled` works normally.

Source files
------------

// File: rtl/mem_access.sv
// Load/store stage: one data-memory transaction per instruction over req/gnt/rvalid.
// Non-memory ops pass rd_in straight through; faults complete without touching memory.
module mem_access #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enabled,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rd_in,
  output logic        completed,
  output logic        busy,
  output logic [31:0] rd_out,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is transferred in the cycle mem_req && mem_gnt are both
  // high; until then addr/wdata/wstrb/we stay stable. Read data is taken in the
  // first WAIT_R cycle with mem_rvalid high; rvalid in any other state is dropped.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   rd_out_q, rd_out_d;
  logic          fault_q, fault_d;
  logic          completed_q, completed_d;
  logic          busy_q, busy_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wstrb_q, mem_wstrb_d;

  logic          legal_op;
  logic          misaligned;
  logic [31:0]   load_val;
  logic [7:0]    lb;
  logic [15:0]   lh;

  // Decode of the incoming instruction, only meaningful while IDLE.
  always_comb begin
    legal_op   = 1'b0;
    misaligned = 1'b0;
    if (is_load && !is_store) begin
      legal_op = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    end else if (is_store && !is_load) begin
      legal_op = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end
    if (funct3[1:0] == 2'b01) misaligned = addr[0];
    if (funct3[1:0] == 2'b10) misaligned = (addr[1:0] != 2'b00);
  end

  // Lane select and extension of returned read data.
  always_comb begin
    case (lane_q)
      2'd0:    lb = mem_rdata[7:0];
      2'd1:    lb = mem_rdata[15:8];
      2'd2:    lb = mem_rdata[23:16];
      default: lb = mem_rdata[31:24];
    endcase
    lh = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{lb[7]}}, lb};
      3'b001:  load_val = {{16{lh[15]}}, lh};
      3'b100:  load_val = {24'h0, lb};
      3'b101:  load_val = {16'h0, lh};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    rd_out_d    = rd_out_q;
    fault_d     = fault_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enabled) begin
          funct3_d = funct3;
          lane_d   = addr[1:0];
          fault_d  = 1'b0;
          rd_out_d = 32'h0;
          if (!is_load && !is_store) begin
            rd_out_d = rd_in;
            state_d  = DONE;
          end else if (!legal_op || misaligned) begin
            fault_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d    = REQ;
            mem_addr_d = {addr[31:2], 2'b00} & ADDR_MASK;
            mem_we_d   = is_store;
            if (is_store) begin
              case (funct3[1:0])
                2'b00: begin
                  mem_wstrb_d = 4'b0001 << addr[1:0];
                  mem_wdata_d = {4{store_data[7:0]}};
                end
                2'b01: begin
                  mem_wstrb_d = 4'b0011 << addr[1:0];
                  mem_wdata_d = {2{store_data[15:0]}};
                end
                default: begin
                  mem_wstrb_d = 4'b1111;
                  mem_wdata_d = store_data;
                end
              endcase
            end else begin
              mem_wstrb_d = 4'b0000;
              mem_wdata_d = 32'h0;
            end
          end
        end
      end

      REQ: begin
        cnt_d = cnt_q + CNT_ONE;
        if (mem_gnt) begin
          if (mem_we_q) begin
            rd_out_d = 32'h0;
            state_d  = DONE;
          end else begin
            state_d = WAIT_R;
          end
        end else if (cnt_q == CNT_LAST) begin
          fault_d  = 1'b1;
          rd_out_d = 32'h0;
          state_d  = DONE;
        end
      end

      WAIT_R: begin
        cnt_d = cnt_q + CNT_ONE;
        if (mem_rvalid) begin
          rd_out_d = load_val;
          state_d  = DONE;
        end else if (cnt_q == CNT_LAST) begin
          fault_d  = 1'b1;
          rd_out_d = 32'h0;
          state_d  = DONE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    mem_req_d   = (state_d == REQ);
    busy_d      = (state_d != IDLE);
    completed_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      rd_out_q    <= 32'h0;
      fault_q     <= 1'b0;
      completed_q <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      rd_out_q    <= rd_out_d;
      fault_q     <= fault_d;
      completed_q <= completed_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign completed = completed_q;
  assign busy      = busy_q;
  assign rd_out    = rd_out_q;
  assign fault     = fault_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, stores, load lanes, faults,
// timeout and reset abort, checked with immediate assertions.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [31:0] rd_in = 32'h0;
  logic        completed, busy, fault;
  logic [31:0] rd_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  mem_access #(.TIMEOUT(4), .ADDR_MASK(32'hFFFF_FFFF)) dut (
    .clk(clk), .rstn(rstn), .enabled(enabled), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
    .rd_in(rd_in), .completed(completed), .busy(busy), .rd_out(rd_out),
    .fault(fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] ri);
    enabled = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    addr = a; store_data = sd; rd_in = ri;
    step();
    enabled = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (completed !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
    check("wait_done", completed, 1'b1);
  endtask

  logic [2:0]  ld_f3   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [31:0] ld_addr [5] = '{32'h2, 32'h3, 32'h2, 32'h0, 32'h0};
  logic [31:0] ld_exp  [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                               32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    int cyc;
    logic [31:0] e;

    // Reset state
    step(); step();
    check("rst_completed", completed, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_out", rd_out, 32'h0);
    check("rst_fault", fault, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wstrb", mem_wstrb, 4'h0);
    check("rst_state", dbg_state, 2'd0);
    rstn = 1'b1;
    step();

    // Pass-through completes in cycle 1
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1234);
    check("pt_completed", completed, 1'b1);
    check("pt_rd_out", rd_out, 32'h1234);
    check("pt_mem_req", mem_req, 1'b0);
    check("pt_fault", fault, 1'b0);
    step();
    check("pt_pulse_end", completed, 1'b0);
    check("pt_idle_busy", busy, 1'b0);
    check("pt_rd_hold", rd_out, 32'h1234);

    // SB at 0x103 with grant withheld; grant lands on the last timeout cycle and wins
    mem_gnt = 1'b0;
    issue(1'b0, 1'b1, 3'b000, 32'h103, 32'hAB, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("sb_mem_req", mem_req, 1'b1);
      check("sb_mem_addr", mem_addr, 32'h100);
      check("sb_mem_wstrb", mem_wstrb, 4'b1000);
      check("sb_mem_wdata", mem_wdata, 32'hABAB_ABAB);
      check("sb_mem_we", mem_we, 1'b1);
      check("sb_no_done", completed, 1'b0);
      if (i < 3) step();
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("sb_completed", completed, 1'b1);
    check("sb_req_drop", mem_req, 1'b0);
    check("sb_rd_out", rd_out, 32'h0);
    check("sb_fault", fault, 1'b0);
    step();

    // SH at 0x6 with immediate grant: completed in cycle 2
    issue(1'b0, 1'b1, 3'b001, 32'h6, 32'h1234_BEEF, 32'h0);
    check("sh_mem_wstrb", mem_wstrb, 4'b1100);
    check("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
    check("sh_mem_addr", mem_addr, 32'h4);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("sh_completed", completed, 1'b1);
    step();

    // SW at 0x8
    issue(1'b0, 1'b1, 3'b010, 32'h8, 32'h1234_5678, 32'h0);
    check("sw_mem_wstrb", mem_wstrb, 4'b1111);
    check("sw_mem_wdata", mem_wdata, 32'h1234_5678);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("sw_completed", completed, 1'b1);
    step();

    // Load lanes, grant immediate, rvalid one cycle later: completed in cycle 3
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(ld_exp[k]);
      mem_gnt = 1'b1;
      issue(1'b1, 1'b0, ld_f3[k], ld_addr[k], 32'h0, 32'h0);
      check("ld_mem_req", mem_req, 1'b1);
      check("ld_mem_we", mem_we, 1'b0);
      check("ld_mem_wstrb", mem_wstrb, 4'h0);
      step();
      mem_gnt = 1'b0;
      check("ld_wait_req", mem_req, 1'b0);
      check("ld_wait_done", completed, 1'b0);
      mem_rvalid = 1'b1; mem_rdata = 32'h80FF_7F01;
      step();
      mem_rvalid = 1'b0;
      check("ld_completed", completed, 1'b1);
      e = exp_q.pop_front();
      check("ld_rd_out", rd_out, e);
      check("ld_fault", fault, 1'b0);
      step();
    end

    // Misaligned LW: fault in cycle 1, no memory access, fault held
    issue(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0);
    check("mis_completed", completed, 1'b1);
    check("mis_fault", fault, 1'b1);
    check("mis_rd_out", rd_out, 32'h0);
    check("mis_mem_req", mem_req, 1'b0);
    step();
    check("mis_fault_hold", fault, 1'b1);
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h55);
    check("mis_fault_clear", fault, 1'b0);
    check("mis_next_rd", rd_out, 32'h55);
    step();

    // Illegal encodings: store with funct3=100, and both load and store
    issue(1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 32'h0);
    check("ill_st_fault", fault, 1'b1);
    check("ill_st_req", mem_req, 1'b0);
    step();
    issue(1'b1, 1'b1, 3'b010, 32'h0, 32'h0, 32'h0);
    check("ill_both_fault", fault, 1'b1);
    check("ill_both_done", completed, 1'b1);
    step();

    // Timeout: granted load, rvalid never arrives
    mem_gnt = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0);
    check("to_fault_clear", fault, 1'b0);
    step();
    mem_gnt = 1'b0;
    wait_done(10, cyc);
    check("to_latency", cyc, 32'd3);
    check("to_fault", fault, 1'b1);
    check("to_rd_out", rd_out, 32'h0);
    check("to_mem_req", mem_req, 1'b0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    check("late_rv_rd_out", rd_out, 32'h0);
    check("late_rv_done", completed, 1'b0);
    check("late_rv_busy", busy, 1'b0);

    // Reset asserted in WAIT_R aborts immediately
    mem_gnt = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0);
    step();
    mem_gnt = 1'b0;
    check("ra_wait_state", dbg_state, 2'd2);
    check("ra_wait_busy", busy, 1'b1);
    rstn = 1'b0;
    #1;
    check("ra_busy", busy, 1'b0);
    check("ra_mem_req", mem_req, 1'b0);
    check("ra_completed", completed, 1'b0);
    check("ra_state", dbg_state, 2'd0);
    step();
    rstn = 1'b1;
    step();
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h9);
    check("ra_after_done", completed, 1'b1);
    check("ra_after_rd", rd_out, 32'h9);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
